// File: rtl/console_pkg.sv
// Shared constants, state encoding and payload types for the text-console controller.
package console_pkg;

  localparam int unsigned DEF_NUM_ROWS  = 3;
  localparam int unsigned DEF_NUM_COLS  = 10;
  localparam logic [7:0]  DEF_FILL_CHAR = 8'h20;

  localparam logic [6:0] CODE_BS    = 7'h08;
  localparam logic [6:0] CODE_LF    = 7'h0A;
  localparam logic [6:0] CODE_FF    = 7'h0C;
  localparam logic [6:0] CODE_CR    = 7'h0D;
  localparam logic [6:0] CTRL_LIMIT = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    FILL,
    CLEAR
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_RETURN,
    CUR_BACK,
    CUR_HOME
  } cur_cmd_t;

  // One stream byte: colour select in the top bit, character/control code below.
  typedef struct packed {
    logic       color_sel;
    logic [6:0] code;
  } stream_byte_t;

endpackage

// File: rtl/console_if.sv
// Stream, host direct-write and character-buffer port bundle of the console controller.
interface console_if
  import console_pkg::*;
#(
  parameter int unsigned ADDR_W = $clog2(DEF_NUM_ROWS * DEF_NUM_COLS)
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]        buf_rdata;

  // slave: the controller; master: host plus character buffer around it
  modport slave (
    input  in_data, in_valid, host_we, host_addr, host_wdata, buf_rdata,
    output in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
  );

  modport master (
    output in_data, in_valid, host_we, host_addr, host_wdata, buf_rdata,
    input  in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
  );
endinterface

// File: rtl/console_cursor.sv
// Cursor row/column counters; wrap_c flags a command that runs off the last row.
module console_cursor
  import console_pkg::*;
#(
  parameter  int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter  int unsigned NUM_COLS = DEF_NUM_COLS,
  localparam int unsigned ROW_W    = $clog2(NUM_ROWS),
  localparam int unsigned COL_W    = $clog2(NUM_COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cur_cmd_t         cmd,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             wrap_c
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  always_comb begin
    wrap_c = (row == LAST_ROW) &&
             (((cmd == CUR_ADVANCE) && (col == LAST_COL)) || (cmd == CUR_NEWLINE));
  end

  // The row saturates on the last line; the scroll that follows moves the text instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else begin
      case (cmd)
        CUR_ADVANCE: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row != LAST_ROW) row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        CUR_NEWLINE: begin
          col <= '0;
          if (row != LAST_ROW) row <= row + ROW_W'(1);
        end
        CUR_RETURN: col <= '0;
        CUR_BACK:   if (col != '0) col <= col - COL_W'(1);
        CUR_HOME: begin
          row <= '0;
          col <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/console_ctrl.sv
// Console write sequencer: stream decode, scroll/clear engine and host write arbitration.
module console_ctrl
  import console_pkg::*;
#(
  parameter  int unsigned NUM_ROWS  = DEF_NUM_ROWS,
  parameter  int unsigned NUM_COLS  = DEF_NUM_COLS,
  parameter  logic [7:0]  FILL_CHAR = DEF_FILL_CHAR,
  localparam int unsigned ADDR_W    = $clog2(NUM_ROWS * NUM_COLS),
  localparam int unsigned ROW_W     = $clog2(NUM_ROWS),
  localparam int unsigned COL_W     = $clog2(NUM_COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  console_if.slave         bus,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy
);

  localparam int unsigned       NUM_CHARS = NUM_ROWS * NUM_COLS;
  localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(NUM_CHARS - NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CHAR = ADDR_W'(NUM_CHARS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(NUM_COLS);
  localparam logic [31:0]       COL_BITS  = 32'(NUM_COLS);

  // row*NUM_COLS+col as a sum of shifted rows, one term per set bit of NUM_COLS
  function automatic logic [ADDR_W-1:0] cell_index(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(c);
    for (int b = 0; b < int'(ADDR_W); b++) begin
      if (COL_BITS[b]) acc = acc + (ADDR_W'(r) << b);
    end
    return acc;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  stream_byte_t      pend_data_q, pend_data_d;
  logic              carry_q, carry_d;
  stream_byte_t      carry_data_q, carry_data_d;
  logic              busy_q;

  stream_byte_t      in_byte;
  logic              in_ready_c, accept, is_ctrl, host_hit, wrap_c;
  cur_cmd_t          cur_cmd;
  logic              buf_we_c;
  logic [ADDR_W-1:0] buf_waddr_c;
  logic [7:0]        buf_wdata_c;

  assign in_byte    = stream_byte_t'(bus.in_data);
  assign in_ready_c = (state_q == IDLE) && !bus.host_we;
  assign accept     = bus.in_valid && in_ready_c;
  assign is_ctrl    = in_byte.code < CTRL_LIMIT;
  assign host_hit   = bus.host_addr <= LAST_CHAR;

  // Stream byte decode into a cursor command.
  always_comb begin
    cur_cmd = CUR_NONE;
    if (accept) begin
      if (!is_ctrl) begin
        cur_cmd = CUR_ADVANCE;
      end else begin
        case (in_byte.code)
          CODE_LF: cur_cmd = CUR_NEWLINE;
          CODE_CR: cur_cmd = CUR_RETURN;
          CODE_BS: cur_cmd = CUR_BACK;
          CODE_FF: cur_cmd = CUR_HOME;
          default: cur_cmd = CUR_NONE;
        endcase
      end
    end
  end

  console_cursor #(
    .NUM_ROWS(NUM_ROWS),
    .NUM_COLS(NUM_COLS)
  ) u_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cur_cmd),
    .row   (cur_row),
    .col   (cur_col),
    .wrap_c(wrap_c)
  );

  // Next state and write-port mux; a host write stalls everything else for its cycle.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    raddr_d      = raddr_q;
    pend_we_d    = pend_we_q && bus.host_we;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    carry_d      = carry_q;
    carry_data_d = carry_data_q;
    buf_we_c     = 1'b0;
    buf_waddr_c  = pend_addr_q;
    buf_wdata_c  = pend_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // A printable byte in the last cell rides along with the scroll and
          // lands directly in its moved-up position on the final copy step.
          if (!is_ctrl && wrap_c) begin
            carry_d      = 1'b1;
            carry_data_d = in_byte;
          end else if (!is_ctrl) begin
            pend_we_d   = 1'b1;
            pend_addr_d = cell_index(cur_row, cur_col);
            pend_data_d = in_byte;
          end
          if (cur_cmd == CUR_HOME) begin
            state_d = CLEAR;
            ptr_d   = '0;
          end else if (wrap_c) begin
            state_d = COPY;
            ptr_d   = '0;
            raddr_d = COLS_A;
          end
        end
      end
      COPY: begin
        if (!bus.host_we) begin
          if (ptr_q == LAST_COPY) begin
            state_d = FILL;
            carry_d = 1'b0;
          end else begin
            raddr_d = ptr_q + COLS_A + ADDR_W'(1);
          end
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      FILL, CLEAR: begin
        if (!bus.host_we) begin
          if (ptr_q == LAST_CHAR) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.host_we) begin
      buf_we_c    = host_hit;
      buf_waddr_c = bus.host_addr;
      buf_wdata_c = bus.host_wdata;
    end else begin
      case (state_q)
        IDLE: buf_we_c = pend_we_q;
        COPY: begin
          buf_we_c    = 1'b1;
          buf_waddr_c = ptr_q;
          buf_wdata_c = (carry_q && (ptr_q == LAST_COPY)) ? carry_data_q : bus.buf_rdata;
        end
        default: begin
          buf_we_c    = 1'b1;
          buf_waddr_c = ptr_q;
          buf_wdata_c = FILL_CHAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      raddr_q      <= '0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      carry_q      <= 1'b0;
      carry_data_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      raddr_q      <= raddr_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      carry_q      <= carry_d;
      carry_data_q <= carry_data_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.buf_we    = buf_we_c;
  assign bus.buf_waddr = buf_waddr_c;
  assign bus.buf_wdata = buf_wdata_c;
  assign bus.buf_raddr = raddr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_console_ctrl.sv
// Directed bench for console_ctrl with a 30-cell character buffer model.
module tb_console_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cur_row;
  logic [3:0] cur_col;
  logic       busy;
  logic [7:0] mem [30];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  console_if #(.ADDR_W(5)) bus ();

  console_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .cur_row(cur_row),
    .cur_col(cur_col),
    .busy   (busy)
  );

  assign bus.buf_rdata = (bus.buf_raddr < 5'd30) ? mem[bus.buf_raddr] : 8'h00;

  always @(posedge clk) begin
    if (bus.buf_we && bus.buf_waddr < 5'd30) mem[bus.buf_waddr] <= bus.buf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, wait for acceptance; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    #3;
    checks++; if (bus.buf_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %0h want 0", bus.buf_we); end
    checks++; if (bus.buf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0h want 0", bus.buf_waddr); end
    checks++; if (bus.buf_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", bus.buf_wdata); end
    checks++; if (bus.buf_raddr !== 5'd0) begin errors++; $display("FAIL reset_raddr: got %0h want 0", bus.buf_raddr); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %0h want 0", busy); end
    checks++; if ({cur_row, cur_col} !== 6'd0) begin errors++; $display("FAIL reset_cursor: got %0d,%0d want 0,0", cur_row, cur_col); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %0h want 1", bus.in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Host writes in IDLE are pass-through and block the stream; also prefills the buffer.
  task automatic test_host_prefill(input logic [7:0] base);
    for (int i = 0; i < 30; i++) begin
      bus.host_we = 1'b1; bus.host_addr = 5'(i); bus.host_wdata = base + 8'(i);
      #1;
      if (i == 7) begin
        checks++; if (bus.buf_we !== 1'b1)    begin errors++; $display("FAIL host_we: got %0h want 1", bus.buf_we); end
        checks++; if (bus.buf_waddr !== 5'd7) begin errors++; $display("FAIL host_waddr: got %0h want 7", bus.buf_waddr); end
        checks++; if (bus.buf_wdata !== base + 8'd7) begin errors++; $display("FAIL host_wdata: got %0h want %0h", bus.buf_wdata, base + 8'd7); end
        checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL host_ready: got %0h want 0", bus.in_ready); end
      end
      tick();
    end
    bus.host_we = 1'b0;
    tick();
  endtask

  task automatic test_ab();
    bus.in_data = 8'h41; bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ab_ready: got %0h want 1", bus.in_ready); end
    tick();
    bus.in_data = 8'h42;
    #1;
    checks++; if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata} !== {1'b1, 5'd0, 8'h41})
      begin errors++; $display("FAIL ab_write_a: got we=%0h a=%0h d=%0h want 1/0/41", bus.buf_we, bus.buf_waddr, bus.buf_wdata); end
    checks++; if (cur_col !== 4'd1) begin errors++; $display("FAIL ab_col1: got %0d want 1", cur_col); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata} !== {1'b1, 5'd1, 8'h42})
      begin errors++; $display("FAIL ab_write_b: got we=%0h a=%0h d=%0h want 1/1/42", bus.buf_we, bus.buf_waddr, bus.buf_wdata); end
    checks++; if ({cur_row, cur_col} !== {2'd0, 4'd2}) begin errors++; $display("FAIL ab_cursor: got %0d,%0d want 0,2", cur_row, cur_col); end
    tick();
    checks++; if (mem[0] !== 8'h41 || mem[1] !== 8'h42) begin errors++; $display("FAIL ab_cells: got %0h %0h want 41 42", mem[0], mem[1]); end
    checks++; if (bus.buf_we !== 1'b0) begin errors++; $display("FAIL ab_idle_we: got %0h want 0", bus.buf_we); end
  endtask

  task automatic test_scroll();
    int cnt = 0;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 29; i++) send_byte(8'h41 + 8'(i));
    tick();
    checks++; if ({cur_row, cur_col} !== {2'd2, 4'd9}) begin errors++; $display("FAIL scroll_pre_cursor: got %0d,%0d want 2,9", cur_row, cur_col); end
    send_byte(8'h5E);
    while (busy && cnt < 100) begin cnt++; tick(); end
    checks++; if (cnt != 30) begin errors++; $display("FAIL scroll_cycles: got %0d want 30", cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL scroll_ready: got %0h want 1", bus.in_ready); end
    checks++; if ({cur_row, cur_col} !== {2'd2, 4'd0}) begin errors++; $display("FAIL scroll_cursor: got %0d,%0d want 2,0", cur_row, cur_col); end
    for (int k = 0; k < 30; k++) begin
      if (k < 20 && mem[k] !== 8'h4B + 8'(k)) bad++;
      if (k >= 20 && mem[k] !== 8'h20) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL scroll_cells: got %0d wrong cells want 0 (cell19=%0h want 5e)", bad, mem[19]); end
  endtask

  task automatic test_clear();
    int cnt = 0;
    int bad = 0;
    send_byte(8'h58);
    send_byte(8'h59);
    send_byte(8'h0C);
    checks++; if ({cur_row, cur_col} !== 6'd0) begin errors++; $display("FAIL clear_cursor: got %0d,%0d want 0,0", cur_row, cur_col); end
    while (busy && cnt < 100) begin cnt++; tick(); end
    checks++; if (cnt != 30) begin errors++; $display("FAIL clear_cycles: got %0d want 30", cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %0h want 1", bus.in_ready); end
    for (int k = 0; k < 30; k++) if (mem[k] !== 8'h20) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_cells: got %0d non-blank want 0", bad); end
  endtask

  task automatic test_cursor_ctrl();
    send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    checks++; if ({cur_row, cur_col} !== {2'd1, 4'd5}) begin errors++; $display("FAIL cur_start: got %0d,%0d want 1,5", cur_row, cur_col); end
    send_byte(8'h08);
    checks++; if ({cur_row, cur_col} !== {2'd1, 4'd4}) begin errors++; $display("FAIL cur_bs: got %0d,%0d want 1,4", cur_row, cur_col); end
    send_byte(8'h0D);
    checks++; if ({cur_row, cur_col} !== {2'd1, 4'd0}) begin errors++; $display("FAIL cur_cr: got %0d,%0d want 1,0", cur_row, cur_col); end
    send_byte(8'h0A);
    checks++; if ({cur_row, cur_col} !== {2'd2, 4'd0}) begin errors++; $display("FAIL cur_lf: got %0d,%0d want 2,0", cur_row, cur_col); end
    send_byte(8'h08);
    checks++; if ({cur_row, cur_col} !== {2'd2, 4'd0}) begin errors++; $display("FAIL cur_bs_col0: got %0d,%0d want 2,0", cur_row, cur_col); end
    send_byte(8'h07);
    checks++; if ({cur_row, cur_col, bus.buf_we, busy} !== {2'd2, 4'd0, 1'b0, 1'b0})
      begin errors++; $display("FAIL cur_bel: got %0d,%0d we=%0h busy=%0h want 2,0 0 0", cur_row, cur_col, bus.buf_we, busy); end
    checks++; if (mem[14] !== 8'h65) begin errors++; $display("FAIL cur_cell14: got %0h want 65", mem[14]); end
  endtask

  task automatic test_host_copy();
    int cnt = 0;
    int bad = 0;
    send_byte(8'h0A);
    while (busy && cnt < 100) begin
      if (cnt == 3) begin
        bus.host_we = 1'b1; bus.host_addr = 5'd7; bus.host_wdata = 8'h5A;
        #1;
        checks++; if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.in_ready} !== {1'b1, 5'd7, 8'h5A, 1'b0})
          begin errors++; $display("FAIL copy_host_mux: got we=%0h a=%0h d=%0h rdy=%0h want 1/7/5a/0", bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.in_ready); end
      end else if (cnt == 4) begin
        bus.host_we = 1'b0;
        #1;
        checks++; if (mem[7] !== 8'h5A) begin errors++; $display("FAIL copy_host_cell: got %0h want 5a", mem[7]); end
        checks++; if (bus.buf_waddr !== 5'd3) begin errors++; $display("FAIL copy_ptr_hold: got %0d want 3", bus.buf_waddr); end
      end
      cnt++;
      tick();
    end
    checks++; if (cnt != 31) begin errors++; $display("FAIL copy_cycles: got %0d want 31", cnt); end
    for (int k = 0; k < 30; k++) begin
      if (k < 5 && mem[k] !== 8'h61 + 8'(k)) bad++;
      if (k >= 5 && mem[k] !== 8'h20) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL copy_cells: got %0d wrong cells want 0 (cell7=%0h want 20)", bad, mem[7]); end
  endtask

  task automatic test_back_to_back();
    bus.in_data = 8'h51; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.host_we = 1'b1; bus.host_addr = 5'd3; bus.host_wdata = 8'hA5;
    #1;
    checks++; if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata} !== {1'b1, 5'd3, 8'hA5})
      begin errors++; $display("FAIL b2b_host_wins: got we=%0h a=%0h d=%0h want 1/3/a5", bus.buf_we, bus.buf_waddr, bus.buf_wdata); end
    tick();
    bus.host_we = 1'b0;
    #1;
    checks++; if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata} !== {1'b1, 5'd20, 8'h51})
      begin errors++; $display("FAIL b2b_pending: got we=%0h a=%0h d=%0h want 1/14/51", bus.buf_we, bus.buf_waddr, bus.buf_wdata); end
    tick();
    checks++; if (mem[20] !== 8'h51 || mem[3] !== 8'hA5) begin errors++; $display("FAIL b2b_cells: got %0h %0h want 51 a5", mem[20], mem[3]); end
    checks++; if (bus.buf_we !== 1'b0) begin errors++; $display("FAIL b2b_we_clear: got %0h want 0", bus.buf_we); end
    bus.host_we = 1'b1; bus.host_addr = 5'd31; bus.host_wdata = 8'h77;
    bus.in_data = 8'h52; bus.in_valid = 1'b1;
    #1;
    checks++; if ({bus.buf_we, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL host_oob: got we=%0h rdy=%0h want 0 0", bus.buf_we, bus.in_ready); end
    tick();
    bus.host_we = 1'b0; bus.in_valid = 1'b0;
    #1;
    checks++; if ({cur_row, cur_col, bus.buf_we} !== {2'd2, 4'd1, 1'b0})
      begin errors++; $display("FAIL host_oob_stall: got %0d,%0d we=%0h want 2,1 0", cur_row, cur_col, bus.buf_we); end
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    test_host_prefill(8'hC0);
    send_byte(8'h0C);
    repeat (12) tick();
    checks++; if ({busy, bus.buf_waddr} !== {1'b1, 5'd12}) begin errors++; $display("FAIL midclr_pos: got busy=%0h a=%0d want 1 12", busy, bus.buf_waddr); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.buf_raddr, busy, bus.in_ready} !== {1'b0, 5'd0, 8'd0, 5'd0, 1'b0, 1'b1})
      begin errors++; $display("FAIL midclr_outputs: got we=%0h wa=%0h wd=%0h ra=%0h busy=%0h rdy=%0h want 0/0/0/0/0/1",
                               bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.buf_raddr, busy, bus.in_ready); end
    checks++; if ({cur_row, cur_col} !== 6'd0) begin errors++; $display("FAIL midclr_cursor: got %0d,%0d want 0,0", cur_row, cur_col); end
    tick();
    tick();
    for (int k = 0; k < 30; k++) begin
      if (k < 12 && mem[k] !== 8'h20) bad++;
      if (k >= 12 && mem[k] !== 8'hC0 + 8'(k)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midclr_cells: got %0d wrong cells want 0", bad); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_host_prefill(8'h80);
    test_ab();
    test_scroll();
    test_clear();
    test_cursor_ctrl();
    test_host_copy();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/console_ctrl.md
# console_ctrl

Character-stream controller that sequences all writes into the VGA text console's character buffer. It consumes a byte stream from the host register interface, tracks a cursor, and interprets a small set of control codes. It performs scroll and clear sequences by driving the buffer's read and write ports. It also arbitrates those ports against direct host writes to individual cells, so software can use either terminal-style output or random-access writes.

## Interface
Parameters:
- NUM_ROWS, 3, text rows in the buffer.
- NUM_COLS, 10, text columns per row.
- FILL_CHAR, 8'h20, byte written to cells by scroll-fill and clear.
- Local ADDR_W = $clog2(NUM_ROWS*NUM_COLS), 5 at defaults.

Ports:
- clk  in  1  system clock (64 MHz nominal).
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  8  stream byte: {color_sel, 7-bit code}.
- in_valid  in  1  stream byte present.
- in_ready  out  1  controller accepts stream byte this cycle.
- host_we  in  1  direct cell write request (priority requester).
- host_addr  in  ADDR_W  direct write cell index.
- host_wdata  in  8  direct write byte.
- buf_we  out  1  buffer write enable.
- buf_waddr  out  ADDR_W  buffer write index.
- buf_wdata  out  8  buffer write data.
- buf_raddr  out  ADDR_W  buffer read index; the buffer returns data combinationally.
- buf_rdata  in  8  buffer read data for buf_raddr.
- cur_row  out  $clog2(NUM_ROWS)  cursor row.
- cur_col  out  $clog2(NUM_COLS)  cursor column.
- busy  out  1  a scroll or clear is in progress.

## Operation
- States: IDLE, COPY, FILL, CLEAR.
- in_ready = (state==IDLE) & ~host_we. A byte is accepted when in_valid & in_ready.
- Control code means in_data[6:0] < 7'h20.
- Printable byte:
  - Write the full byte at row*NUM_COLS+col.
  - col+1. If col was NUM_COLS-1: col=0 and row+1.
  - If row was already NUM_ROWS-1: row stays, go to COPY.
- 0x0A (LF): col=0. Then row+1, or COPY if row is NUM_ROWS-1.
- 0x0D (CR): col=0.
- 0x08 (BS): col-1 if col>0, else no change. The cell is not erased.
- 0x0C (FF): go to CLEAR. Cursor is set to (0,0).
- Other control codes: consumed, no effect.
- The index row*NUM_COLS+col is formed by shift-add, with no multiplier.
- COPY:
  - ptr runs 0 .. NUM_CHARS-NUM_COLS-1.
  - Each cycle: buf_raddr=ptr+NUM_COLS, buf_waddr=ptr, buf_wdata=buf_rdata, buf_we=1.
  - After the last ptr, go to FILL.
- FILL:
  - ptr runs NUM_CHARS-NUM_COLS .. NUM_CHARS-1.
  - Each cycle: write FILL_CHAR. After the last ptr, go to IDLE.
- CLEAR:
  - ptr runs 0 .. NUM_CHARS-1.
  - Each cycle: write FILL_CHAR. After the last ptr, go to IDLE.
- Arbitration: host_we has absolute priority on the write port in every state.
  - In that cycle buf_waddr/buf_wdata = host_addr/host_wdata and buf_we=1.
  - The sequencer stalls: ptr and state hold, and no stream byte is accepted.
  - Host indices ≥ NUM_CHARS are ignored (buf_we=0). The sequencer still stalls.
- busy = (state!=IDLE).

## Timing
- Reset values:
  - state IDLE, ptr 0, cursor (0,0).
  - buf_we 0, buf_waddr 0, buf_raddr 0, buf_wdata 0, busy 0.
  - in_ready follows its equation (1 when host_we=0).
- Stream writes: buf_we/buf_waddr/buf_wdata are registered. The write appears 1 cycle after acceptance.
- Cursor updates on the acceptance edge.
- Host writes are combinational pass-through, 0 cycle latency. This bypasses the register in that cycle only.
- COPY: buf_raddr is registered. buf_wdata is a combinational mux from buf_rdata.
- Scroll cost: exactly NUM_CHARS cycles with no host stalls (30 at defaults).
- Clear cost: NUM_CHARS cycles.
- in_ready returns high in the cycle after the last FILL/CLEAR write.
- A host write and a registered stream write due in the same cycle: the host write wins. The pending stream write is held and issued the next cycle.
- Reset mid-sequence aborts immediately. Buffer contents are left partially moved and are not repaired.
- The cursor wraps only through a scroll. It never points outside the buffer.

## Structure
- Package console_pkg: NUM_ROWS/NUM_COLS defaults, control-code constants (LF, CR, BS, FF), state enum.
- Optional sub-module console_cursor: row/col counters with advance/newline/backspace/home commands and a wrap flag output.
- The FSM, ptr, and arbitration mux stay in console_ctrl.

## Test plan
- Reset, then stream "AB": cells 0/1 written 0x41/0x42 one cycle after each accept; cursor (0,2).
- Write 30 printable bytes 0x41+i with the buffer prefilled: the 30th byte triggers a scroll.
  - busy for 30 cycles.
  - Cells 0-19 hold the old cells 10-29; cells 20-29 = 0x20; cursor (2,0).
- 0x0C after partial fill: all 30 cells = 0x20 after 30 cycles; cursor (0,0); in_ready high next cycle.
- At (1,5) send 0x08, 0x0D, 0x0A: cursor (1,4), then (1,0), then (2,0). Byte 0x07 has no effect.
- host_we at addr 7 data 0x5A during COPY ptr=3:
  - cell 7 = 0x5A that cycle; ptr holds; scroll completes in 31 cycles.
  - host addr 31 produces no write.
- Assert rst_n low mid-CLEAR at ptr=12: outputs at reset values; cells 12-29 unchanged; cursor (0,0).
